// File: rtl/dpram_rd_pkg.sv
// Shared defaults and FSM encoding for the DPRAM stream reader.
package dpram_rd_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 64;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

endpackage

// File: rtl/dpram_rd_skid.sv
// Two-entry FIFO that absorbs RAM read data while the stream stalls.
module dpram_rd_skid
    import dpram_rd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] mem0;
    logic [DATA_W-1:0] mem1;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign data    = rd_ptr ? mem1 : mem0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0   <= '0;
            mem1   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_ptr) mem1 <= din;
                else        mem0 <= din;
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/dpram_stream_reader.sv
// Streams a block of RAM words out through a valid/ready port,
// keeping at most two words outstanding between RAM and consumer.
module dpram_stream_reader
    import dpram_rd_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              ren,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   rd_cnt;
    logic [ADDR_W:0]   beat_cnt;
    logic              rvalid;
    logic              f_full;
    logic              f_empty;
    logic              pop;
    logic [1:0]        occ;
    logic              room;
    logic              last_rd;

    assign m_valid = ~f_empty;
    assign pop     = m_valid & m_ready;
    assign raddr   = addr_q;

    // A slot freed by this cycle's pop may be reused by this cycle's read.
    always_comb begin
        occ  = {1'b0, rvalid} + (f_full ? 2'd2 : {1'b0, ~f_empty});
        room = (occ < 2'd2) || ((occ == 2'd2) && pop);
    end

    assign ren     = (state == READ) && room;
    assign last_rd = ren && ((rd_cnt + CNT_ONE) == len_q);
    assign m_last  = m_valid && ((beat_cnt + CNT_ONE) == len_q);

    dpram_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rvalid),
        .pop   (pop),
        .din   (rdata),
        .full  (f_full),
        .empty (f_empty),
        .data  (m_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            rd_cnt   <= '0;
            beat_cnt <= '0;
            rvalid   <= 1'b0;
        end else begin
            done   <= 1'b0;
            rvalid <= ren;
            if (ren) begin
                addr_q <= addr_q + ADDR_W'(1);
                rd_cnt <= rd_cnt + CNT_ONE;
            end
            if (pop) beat_cnt <= beat_cnt + CNT_ONE;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addr_q   <= base_addr;
                        len_q    <= length;
                        rd_cnt   <= '0;
                        beat_cnt <= '0;
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (last_rd) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed bench with a queue-based stream model for dpram_stream_reader.
module tb_dpram_stream_reader;

    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          m_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, ren, m_valid, m_last;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic [DW-1:0] m_data;
    logic [DW-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dpram_stream_reader #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .ren       (ren),
        .raddr     (raddr),
        .rdata     (rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    function automatic logic [63:0] word(int i);
        logic [31:0] u;
        u = 32'hDA7A_0000 | 32'(i);
        return {u, ~u};
    endfunction

    initial for (int i = 0; i < DEPTH; i++) mem[i] = word(i);

    // RAM with one-cycle read latency
    always @(posedge clk) if (ren) rdata <= mem[raddr];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_ren"}, 64'(ren), 64'd0);
        chk({tag, "_raddr"}, 64'(raddr), 64'd0);
        chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_m_last"}, 64'(m_last), 64'd0);
        chk({tag, "_m_data"}, m_data, 64'd0);
    endtask

    // Stream model: jobs expand into expected addresses and beats.
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_data [$];
    bit            exp_last [$];
    bit            active = 0;
    bit            pend_last = 0;
    bit            done_exp = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    int            issued = 0;
    int            xfer = 0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_addr.delete();
            exp_data.delete();
            exp_last.delete();
            active = 0;
            pend_last = 0;
            done_exp = 0;
            prev_stall = 0;
            issued = 0;
            xfer = 0;
            chk_zero("in_reset");
        end else begin
            chk("done", 64'(done), 64'(done_exp));
            chk("busy", 64'(busy), 64'(active));
            if (prev_stall) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_data", m_data, prev_data);
            end
            if (ren) begin
                issued++;
                chk("ren_expected", 64'(exp_addr.size() != 0), 64'd1);
                if (exp_addr.size() != 0)
                    chk("raddr", 64'(raddr), 64'(exp_addr.pop_front()));
            end
            if (m_valid) begin
                chk("valid_expected", 64'(exp_data.size() != 0), 64'd1);
                if (exp_data.size() != 0) begin
                    chk("m_last", 64'(m_last), 64'(exp_last[0]));
                    if (m_ready) begin
                        chk("m_data", m_data, exp_data.pop_front());
                        if (exp_last.pop_front()) pend_last = 1;
                        xfer++;
                    end
                end
            end
            if (issued - xfer > 2)
                chk("outstanding", 64'(issued - xfer), 64'd2);
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
        end
        @(posedge clk);
        done_exp = 0;
        if (rst_n) begin
            if (start && !active) begin
                if (length == '0) begin
                    done_exp = 1;
                end else begin
                    active = 1;
                    for (int k = 0; k < int'(length); k++) begin
                        exp_addr.push_back(AW'((int'(base_addr) + k) % DEPTH));
                        exp_data.push_back(mem[(int'(base_addr) + k) % DEPTH]);
                        exp_last.push_back(k == int'(length) - 1);
                    end
                end
            end
            if (pend_last) begin
                active = 0;
                done_exp = 1;
                pend_last = 0;
            end
        end
    end

    int            r_beats, r_first_v, r_done_n, r_ren, r_gaps;
    bit            r_busy;
    logic [DW-1:0] r_first_data, r_last_data;
    logic [3:0]    pat = 4'b1001;

    task automatic run_job(input int b, input int l, input int mode,
                           input bit immediate, input int abort_at);
        if (!immediate) begin
            @(posedge clk);
            #1;
        end else begin
            #1;
        end
        base_addr = AW'(b);
        length = (AW+1)'(l);
        start = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        r_beats = 0;
        r_first_v = -1;
        r_done_n = -1;
        r_ren = 0;
        r_gaps = 0;
        r_busy = 0;
        r_first_data = '0;
        r_last_data = '0;
        for (int n = 1; n <= 1200; n++) begin
            m_ready = (mode == 0) ? 1'b1 : pat[n % 4];
            @(negedge clk);
            if (busy) r_busy = 1;
            if (ren) r_ren++;
            if (m_valid && r_first_v < 0) r_first_v = n;
            if (r_first_v > 0 && !m_valid && r_beats < l) r_gaps++;
            if (m_valid && m_ready) begin
                r_beats++;
                if (r_beats == 1) r_first_data = m_data;
                r_last_data = m_data;
            end
            if (done) begin
                r_done_n = n;
                break;
            end
            if (abort_at > 0 && r_beats == abort_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk_zero("abort");
                break;
            end
            @(posedge clk);
            #1;
        end
        if (abort_at == 0)
            chk("job_finished", 64'(r_done_n > 0), 64'd1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_zero("por");
        #1 rst_n = 1'b1;

        run_job(5, 4, 0, 0, 0);
        chk("t1_first_v", 64'(r_first_v), 64'd3);
        chk("t1_beats", 64'(r_beats), 64'd4);
        chk("t1_first", r_first_data, 64'hDA7A0005_2585FFFA);
        chk("t1_last", r_last_data, 64'hDA7A0008_2585FFF7);
        chk("t1_done_n", 64'(r_done_n), 64'd7);

        run_job(1022, 4, 0, 0, 0);
        chk("t2_beats", 64'(r_beats), 64'd4);
        chk("t2_first", r_first_data, 64'hDA7A03FE_2585FC01);
        chk("t2_last", r_last_data, 64'hDA7A0001_2585FFFE);

        run_job(300, 8, 1, 0, 0);
        chk("t3_beats", 64'(r_beats), 64'd8);
        chk("t3_first", r_first_data, 64'hDA7A012C_2585FED3);
        chk("t3_last", r_last_data, 64'hDA7A0133_2585FECC);

        run_job(77, 0, 0, 0, 0);
        chk("t4_done_n", 64'(r_done_n), 64'd1);
        chk("t4_busy", 64'(r_busy), 64'd0);
        chk("t4_ren", 64'(r_ren), 64'd0);
        chk("t4_beats", 64'(r_beats), 64'd0);

        run_job(40, 3, 0, 0, 0);
        chk("t5a_beats", 64'(r_beats), 64'd3);
        run_job(50, 2, 0, 1, 0);
        chk("t5b_done_n", 64'(r_done_n), 64'd5);
        chk("t5b_last", r_last_data, 64'hDA7A0033_2585FFCC);

        run_job(0, 1024, 0, 0, 0);
        chk("t6_first_v", 64'(r_first_v), 64'd3);
        chk("t6_beats", 64'(r_beats), 64'd1024);
        chk("t6_gaps", 64'(r_gaps), 64'd0);
        chk("t6_last", r_last_data, 64'hDA7A03FF_2585FC00);
        chk("t6_done_n", 64'(r_done_n), 64'd1027);

        run_job(100, 10, 0, 0, 3);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("t7_no_done", 64'(done), 64'd0);
        end
        #1 rst_n = 1'b1;
        run_job(900, 2, 0, 0, 0);
        chk("t7_beats", 64'(r_beats), 64'd2);
        chk("t7_first", r_first_data, 64'hDA7A0384_2585FC7B);
        chk("t7_last", r_last_data, 64'hDA7A0385_2585FC7A);
        chk("t7_done_n", 64'(r_done_n), 64'd5);

        repeat (3) @(negedge clk);
        chk("model_drained", 64'(exp_data.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
